hex_display_scanner: RTL and testbench

- Time-multiplexes a NUM_DIGITS-digit hex word onto one shared seven-segment decoder.
- Each scan slot outputs one nibble to the decoder's nIn and drives one active-low digit enable.
- Sits directly upstream of the seven-segment decoder, between datapath result registers and the board's common-anode display.
- Inserts a ghosting dead-time at every digit switch.

---
 rtl/display_pkg.sv | 21 ++
 rtl/scan_tick_gen.sv | 41 ++++
 rtl/hex_display_scanner.sv | 136 +++++++++++++
 tb/tb_hex_display_scanner.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and helpers for the multiplexed hex display scanner.
package display_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

  // Never returns 0 so that single-value counters still get a 1-bit register.
  function automatic int clog2(input int value);
    int width;
    width = 0;
    while ((1 << width) < value) begin
      width++;
    end
    return (width < 1) ? 1 : width;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Slot-timing counter: counts 0..PRESCALE-1 while running and flags the last cycle of a slot.
module scan_tick_gen
  import display_pkg::*;
#(
  parameter int PRESCALE = 50000,
  parameter int CNT_W    = clog2(PRESCALE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             tick
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = (cnt_q == CNT_W'(PRESCALE - 1));
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr || !run) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hex_display_scanner.sv
// Scans a NUM_DIGITS hex word onto one shared seven-segment decoder with a dead-time per slot.
// Optional leading-zero suppression is enabled by defining LEADING_ZERO_BLANK_EN.
module hex_display_scanner
  import display_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int PRESCALE    = 50000,
  parameter int DEAD_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          disp_en,
  input  logic                          load,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] data_in,
  output logic [DIGIT_W-1:0]            nibble_out,
  output logic [NUM_DIGITS-1:0]         digit_sel_L,
  output logic                          blank,
  output logic                          frame_done
);

  localparam int DATA_W = DIGIT_W * NUM_DIGITS;
  localparam int CNT_W  = clog2(PRESCALE);
  localparam int IDX_W  = clog2(NUM_DIGITS);

  scan_state_t       state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic [CNT_W-1:0]      cnt;
  logic                  tick;
  logic                  run;
  logic                  clr;
  logic                  in_dead;
  logic                  cur_suppress;
  logic                  lit;
  logic [DIGIT_W-1:0]    digit [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] suppress;

  assign run = (state_q == SCAN);

  scan_tick_gen #(
    .PRESCALE (PRESCALE),
    .CNT_W    (CNT_W)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .run  (run),
    .clr  (clr),
    .cnt  (cnt),
    .tick (tick)
  );

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign digit[gi] = data_q[gi*DIGIT_W +: DIGIT_W];
    end
    if (DEAD_CYCLES == 0) begin : g_no_dead
      assign in_dead = 1'b0;
    end else begin : g_dead
      assign in_dead = (cnt < CNT_W'(DEAD_CYCLES));
    end
  endgenerate

`ifdef LEADING_ZERO_BLANK_EN
  // Walk down from the top digit; a digit hides while everything above it is zero too.
  always_comb begin
    logic all_zero;
    all_zero = 1'b1;
    suppress = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      all_zero    = all_zero && (digit[i] == '0);
      suppress[i] = all_zero;
    end
  end
`else
  assign suppress = '0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = load ? data_in : data_q;
    clr     = 1'b0;
    case (state_q)
      IDLE: begin
        idx_d = '0;
        if (disp_en) begin
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (!disp_en) begin
          state_d = IDLE;
          idx_d   = '0;
          clr     = 1'b1;
        end else if (tick) begin
          idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    nibble_out   = '0;
    cur_suppress = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nibble_out   = digit[i];
        cur_suppress = suppress[i];
      end
    end
    lit         = run && !in_dead && !cur_suppress;
    digit_sel_L = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (lit && (idx_q == IDX_W'(i))) begin
        digit_sel_L[i] = 1'b0;
      end
    end
    blank      = &digit_sel_L;
    frame_done = run && tick && (idx_q == IDX_W'(NUM_DIGITS - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed bench for hex_display_scanner with NUM_DIGITS=4, PRESCALE=4, DEAD_CYCLES=1.
module tb_hex_display_scanner;

  logic        clk;
  logic        rst;
  logic        disp_en;
  logic        load;
  logic [15:0] data_in;
  logic [3:0]  nibble_out;
  logic [3:0]  digit_sel_L;
  logic        blank;
  logic        frame_done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [3:0] lit_sel [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [3:0] lit_nib [4] = '{4'h0, 4'hA, 4'h2, 4'h1};

  hex_display_scanner #(
    .NUM_DIGITS  (4),
    .PRESCALE    (4),
    .DEAD_CYCLES (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .disp_en     (disp_en),
    .load        (load),
    .data_in     (data_in),
    .nibble_out  (nibble_out),
    .digit_sel_L (digit_sel_L),
    .blank       (blank),
    .frame_done  (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Loads d from IDLE, enables scanning, and returns at the negedge of the first SCAN cycle.
  task automatic start_scan(input logic [15:0] d);
    @(negedge clk);
    load = 1'b1; data_in = d; disp_en = 1'b0;
    @(negedge clk);
    load = 1'b0; disp_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; disp_en = 1'b0; load = 1'b0; data_in = 16'h0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({digit_sel_L, blank, nibble_out, frame_done} !== {4'b1111, 1'b1, 4'h0, 1'b0})
      $display("FAIL reset_held: sel=%b blank=%b nib=%h fd=%b expected sel=1111 blank=1 nib=0 fd=0",
               digit_sel_L, blank, nibble_out, frame_done);
    else pass_cnt++;
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      total_cnt++;
      if ({digit_sel_L, blank, nibble_out, frame_done} !== {4'b1111, 1'b1, 4'h0, 1'b0})
        $display("FAIL idle_after_reset cyc %0d: sel=%b blank=%b nib=%h fd=%b expected sel=1111 blank=1 nib=0 fd=0",
                 k, digit_sel_L, blank, nibble_out, frame_done);
      else pass_cnt++;
    end
    $display("test_reset done");
  endtask

  task automatic test_scan();
    int fd_count;
    int idx;
    int cnt;
    logic [3:0] exp_sel;
    logic       exp_fd;
    fd_count = 0;
    start_scan(16'h12A0);
    for (int k = 0; k < 32; k++) begin
      idx     = (k / 4) % 4;
      cnt     = k % 4;
      exp_sel = (cnt == 0) ? 4'b1111 : lit_sel[idx];
      exp_fd  = (idx == 3) && (cnt == 3);
      total_cnt++;
      if ({digit_sel_L, blank, nibble_out, frame_done} !== {exp_sel, (cnt == 0), lit_nib[idx], exp_fd})
        $display("FAIL scan cyc %0d: sel=%b blank=%b nib=%h fd=%b expected sel=%b blank=%b nib=%h fd=%b",
                 k, digit_sel_L, blank, nibble_out, frame_done, exp_sel, (cnt == 0), lit_nib[idx], exp_fd);
      else pass_cnt++;
      if (frame_done === 1'b1) fd_count++;
      @(negedge clk);
    end
    total_cnt++;
    if (fd_count != 2)
      $display("FAIL frame_done_count: got %0d pulses expected 2", fd_count);
    else pass_cnt++;
    disp_en = 1'b0;
    $display("test_scan done");
  endtask

  task automatic test_load_on_switch();
    start_scan(16'h12A0);
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({digit_sel_L, nibble_out} !== {4'b1110, 4'h0})
      $display("FAIL switch_before: sel=%b nib=%h expected sel=1110 nib=0", digit_sel_L, nibble_out);
    else pass_cnt++;
    load = 1'b1; data_in = 16'hFFFF;
    @(negedge clk);
    load = 1'b0;
    total_cnt++;
    if ({digit_sel_L, nibble_out} !== {4'b1111, 4'hF})
      $display("FAIL switch_dead: sel=%b nib=%h expected sel=1111 nib=f", digit_sel_L, nibble_out);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({digit_sel_L, nibble_out} !== {4'b1101, 4'hF})
      $display("FAIL switch_lit: sel=%b nib=%h expected sel=1101 nib=f", digit_sel_L, nibble_out);
    else pass_cnt++;
    disp_en = 1'b0;
    $display("test_load_on_switch done");
  endtask

  task automatic test_disable_mid_slot();
    start_scan(16'h12A0);
    repeat (10) @(negedge clk);
    total_cnt++;
    if ({digit_sel_L, nibble_out} !== {4'b1011, 4'h2})
      $display("FAIL pre_disable: sel=%b nib=%h expected sel=1011 nib=2", digit_sel_L, nibble_out);
    else pass_cnt++;
    disp_en = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      total_cnt++;
      if ({digit_sel_L, blank, nibble_out, frame_done} !== {4'b1111, 1'b1, 4'h0, 1'b0})
        $display("FAIL disabled cyc %0d: sel=%b blank=%b nib=%h fd=%b expected sel=1111 blank=1 nib=0 fd=0",
                 k, digit_sel_L, blank, nibble_out, frame_done);
      else pass_cnt++;
    end
    disp_en = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({digit_sel_L, blank, nibble_out} !== {4'b1111, 1'b1, 4'h0})
      $display("FAIL reenable_dead: sel=%b blank=%b nib=%h expected sel=1111 blank=1 nib=0",
               digit_sel_L, blank, nibble_out);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({digit_sel_L, blank, nibble_out} !== {4'b1110, 1'b0, 4'h0})
      $display("FAIL reenable_lit: sel=%b blank=%b nib=%h expected sel=1110 blank=0 nib=0",
               digit_sel_L, blank, nibble_out);
    else pass_cnt++;
    disp_en = 1'b0;
    $display("test_disable_mid_slot done");
  endtask

  task automatic test_leading_zero();
    logic [15:0] vec_data [3] = '{16'h00A0, 16'h0000, 16'h1001};
`ifdef LEADING_ZERO_BLANK_EN
    logic [3:0]  vec_mask [3] = '{4'b0011, 4'b0001, 4'b1111};
`else
    logic [3:0]  vec_mask [3] = '{4'b1111, 4'b1111, 4'b1111};
`endif
    logic [15:0] d;
    logic [3:0]  m;
    logic [3:0]  exp_sel;
    logic [3:0]  exp_nib;
    logic        exp_lit;
    int idx;
    int cnt;
    for (int v = 0; v < 3; v++) begin
      d = vec_data[v];
      m = vec_mask[v];
      start_scan(d);
      for (int k = 0; k < 16; k++) begin
        idx     = k / 4;
        cnt     = k % 4;
        exp_lit = (cnt != 0) && m[idx];
        exp_sel = exp_lit ? lit_sel[idx] : 4'b1111;
        exp_nib = d[4*idx +: 4];
        total_cnt++;
        if ({digit_sel_L, blank, nibble_out} !== {exp_sel, !exp_lit, exp_nib})
          $display("FAIL lzb data %h cyc %0d: sel=%b blank=%b nib=%h expected sel=%b blank=%b nib=%h",
                   d, k, digit_sel_L, blank, nibble_out, exp_sel, !exp_lit, exp_nib);
        else pass_cnt++;
        @(negedge clk);
      end
      disp_en = 1'b0;
      $display("test_leading_zero data %h done", d);
    end
  endtask

  task automatic test_async_reset();
    int cnt;
    logic [3:0] exp_sel;
    start_scan(16'h12A0);
    repeat (6) @(negedge clk);
    total_cnt++;
    if ({digit_sel_L, nibble_out} !== {4'b1101, 4'hA})
      $display("FAIL pre_async_reset: sel=%b nib=%h expected sel=1101 nib=a", digit_sel_L, nibble_out);
    else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total_cnt++;
    if ({digit_sel_L, blank, nibble_out, frame_done} !== {4'b1111, 1'b1, 4'h0, 1'b0})
      $display("FAIL async_reset: sel=%b blank=%b nib=%h fd=%b expected sel=1111 blank=1 nib=0 fd=0",
               digit_sel_L, blank, nibble_out, frame_done);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      cnt     = k % 4;
`ifdef LEADING_ZERO_BLANK_EN
      exp_sel = (cnt != 0 && k < 4) ? lit_sel[0] : 4'b1111;
`else
      exp_sel = (cnt != 0) ? lit_sel[k / 4] : 4'b1111;
`endif
      total_cnt++;
      if ({digit_sel_L, nibble_out} !== {exp_sel, 4'h0})
        $display("FAIL post_reset_data cyc %0d: sel=%b nib=%h expected sel=%b nib=0",
                 k, digit_sel_L, nibble_out, exp_sel);
      else pass_cnt++;
      @(negedge clk);
    end
    disp_en = 1'b0;
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load_on_switch();
    test_disable_mid_slot();
    test_leading_zero();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
